pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The module SHALL have parameter PC_STEP, default 32'd4, meaning the sequential PC increment.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The module SHALL have port en, input, 1 bit: fetch enable, sampled in IDLE and on HOLD release.
REQ-006 The module SHALL have port stall, input, 1 bit: downstream not ready; holds the fetched instruction.
REQ-007 The module SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 The module SHALL have port redirect_pc, input, 32 bits: redirect target address.
REQ-009 The module SHALL have port imem_req, output, 1 bit: instruction-memory request.
REQ-010 The module SHALL have port imem_addr, output, 32 bits: request address.
REQ-011 The module SHALL have port imem_ack, input, 1 bit: response valid, qualified by imem_req.
REQ-012 The module SHALL have port imem_rdata, input, 32 bits: response data, valid with imem_ack.
REQ-013 The module SHALL have port ifetch_valid, output, 1 bit: fetched instruction valid.
REQ-014 The module SHALL have port ifetch_pc, output, 32 bits: address of the fetched instruction.
REQ-015 The module SHALL have port ifetch_instr, output, 32 bits: fetched instruction word.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, FETCH, HOLD and FLUSH.
REQ-017 In IDLE, en=1 SHALL move the FSM to FETCH on the next cycle.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the pc register, both held stable until imem_ack.
REQ-019 In FETCH, imem_ack=1 SHALL register imem_rdata into ifetch_instr, set ifetch_pc to the pc register, set ifetch_valid=1 on the next cycle, update pc to pc+PC_STEP (mod 2^32, so 32'hFFFF_FFFC+4 gives 0) and move the FSM to HOLD.
REQ-020 In HOLD with stall=1, imem_req SHALL be 0 and ifetch_valid, ifetch_pc and ifetch_instr SHALL be held unchanged.
REQ-021 In HOLD with stall=0, ifetch_valid SHALL drop to 0 on the next cycle, and the FSM SHALL go to FETCH if en=1 or to IDLE if en=0.
REQ-022 Redirect priority SHALL be: redirect_valid overrides stall and en.
REQ-023 redirect_valid in IDLE or HOLD SHALL load pc with {redirect_pc[31:2],2'b00}, clear ifetch_valid on the next cycle, and move the FSM to FETCH.
REQ-024 redirect_valid in FETCH without imem_ack SHALL store the aligned target and move the FSM to FLUSH; the outstanding request SHALL NOT be withdrawn.
REQ-025 redirect_valid in FETCH coinciding with imem_ack SHALL discard the response (ifetch_valid stays 0), load pc with the target and remain in FETCH, issuing the new address on the next cycle.
REQ-026 In FLUSH, imem_req SHALL stay 1 at the old address until imem_ack; that response SHALL be discarded; the FSM SHALL then enter FETCH with the stored target.
REQ-027 redirect_valid during FLUSH SHALL overwrite the stored target, with the last one winning.
REQ-028 imem_ack SHALL be ignored whenever imem_req=0.
REQ-029 The design SHALL allow at most one outstanding request, with a minimum of 2 cycles per delivered instruction.

Reset
REQ-030 Asserting rst (rst=0) SHALL asynchronously force: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ifetch_valid=0, ifetch_pc=0, ifetch_instr=0.
REQ-031 Reset mid-FETCH or mid-FLUSH SHALL abandon the transaction, and any later imem_ack for it SHALL be ignored.
REQ-032 Reset deassertion SHALL take effect on the first posedge clk with rst=1.

Structure
REQ-033 The state enum, RESET_PC default and PC_STEP default SHALL live in a shared package, pc_pkg.
REQ-034 The PC arithmetic (pc+PC_STEP and the select between RESET_PC, increment and redirect) SHALL be one sub-module, pc_next_calc, which is combinational with 32-bit wrap.
REQ-035 All outputs SHALL be driven from registers or from the FSM state only, with no combinational path from imem_ack to imem_req.

Verification
REQ-036 The bench SHALL cover this scenario: reset, en=1, ack 1 cycle after each req, stall=0 -> imem_addr sequence 0,4,8,C; ifetch_valid pulses carry the matching ifetch_pc.
REQ-037 The bench SHALL cover this scenario: stall=1 for 5 cycles after the delivery of pc=8 -> ifetch_valid=1 held, ifetch_instr stable, imem_req=0; release leads to a fetch of C.
REQ-038 The bench SHALL cover this scenario: redirect_pc=32'h100 while in FETCH at addr 4 with ack 3 cycles later -> req held at 4, data discarded, next imem_addr=100, no ifetch_valid for 4.
REQ-039 The bench SHALL cover this scenario: redirect_pc=32'h203 coincident with ack -> response dropped, next imem_addr=200.
REQ-040 The bench SHALL cover this scenario: RESET_PC=32'hFFFF_FFFC -> second fetch address is 0.
REQ-041 The bench SHALL cover this scenario: rst=0 asserted mid-FLUSH with a later ack -> all outputs at reset values, no ifetch_valid, first fetch at RESET_PC.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch PC sequencer.
// Holds the FSM state set, PC select codes and the alignment helper.
package pc_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    FLUSH
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_TGT,
    SEL_RESET
  } pc_sel_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC select: hold, step, redirect target or reset PC.
// The increment wraps naturally at 32 bits.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  pc_sel_t     sel,
  input  logic [31:0] pc,
  input  logic [31:0] target,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_next = pc;
    unique case (sel)
      SEL_HOLD:  pc_next = pc;
      SEL_INC:   pc_next = pc + PC_STEP;
      SEL_TGT:   pc_next = target;
      SEL_RESET: pc_next = RESET_PC;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request at a time,
// with stall hold and redirect handling including in-flight flush.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ifetch_valid,
  output logic [31:0] ifetch_pc,
  output logic [31:0] ifetch_instr
);

  state_t      state;
  pc_sel_t     sel;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] redir;
  logic [31:0] tgt;
  logic [31:0] pc_next;
  logic        ack;

  assign ack   = imem_ack & imem_req;
  assign redir = align_pc(redirect_pc);
  // A fresh redirect always beats the stored one
  assign tgt   = redirect_valid ? redir : target;

  always_comb begin
    sel = SEL_HOLD;
    unique case (state)
      IDLE, HOLD: if (redirect_valid) sel = SEL_TGT;
      FETCH: begin
        if (ack) sel = redirect_valid ? SEL_TGT : SEL_INC;
      end
      FLUSH: if (ack) sel = SEL_TGT;
      default: sel = SEL_HOLD;
    endcase
  end

  pc_next_calc #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_next (
    .sel     (sel),
    .pc      (pc),
    .target  (tgt),
    .pc_next (pc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      target       <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      ifetch_valid <= 1'b0;
      ifetch_pc    <= 32'h0;
      ifetch_instr <= 32'h0;
    end else begin
      pc <= pc_next;
      unique case (state)
        IDLE: begin
          if (redirect_valid || en) begin
            state        <= FETCH;
            imem_req     <= 1'b1;
            imem_addr    <= pc_next;
            ifetch_valid <= 1'b0;
          end
        end
        FETCH: begin
          if (ack && redirect_valid) begin
            imem_addr <= pc_next;
          end else if (redirect_valid) begin
            target <= redir;
            state  <= FLUSH;
          end else if (ack) begin
            ifetch_instr <= imem_rdata;
            ifetch_pc    <= pc;
            ifetch_valid <= 1'b1;
            imem_req     <= 1'b0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            ifetch_valid <= 1'b0;
            imem_req     <= 1'b1;
            imem_addr    <= pc_next;
            state        <= FETCH;
          end else if (!stall) begin
            ifetch_valid <= 1'b0;
            if (en) begin
              imem_req  <= 1'b1;
              imem_addr <= pc_next;
              state     <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          // Old request stays up until its response is swallowed
          if (ack) begin
            imem_addr <= pc_next;
            state     <= FETCH;
          end else if (redirect_valid) begin
            target <= redir;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a transaction model.
// A second instance with a wrap-around reset PC shares all inputs.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        fv0, fv1;
  logic [31:0] fpc0, fpc1;
  logic [31:0] fin0, fin1;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mpc;
  logic [31:0] d;
  logic [31:0] r1;
  logic [31:0] r2;
  logic [31:0] old;
  int          lat;
  int          kind;
  int          n;

  always #5 clk = ~clk;

  pc_sequencer dut0 (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (req0),
    .imem_addr      (addr0),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .ifetch_valid   (fv0),
    .ifetch_pc      (fpc0),
    .ifetch_instr   (fin0)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (req1),
    .imem_addr      (addr1),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .ifetch_valid   (fv1),
    .ifetch_pc      (fpc1),
    .ifetch_instr   (fin1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a - (a % 4);
  endfunction

  // Serve the pending request after lat cycles and check the delivery
  task automatic deliver(input int l, input logic [31:0] a,
                         input logic [31:0] dat);
    for (int i = 0; i < l; i++) begin
      chk("req_up", 32'(req0), 32'd1);
      chk("req_addr", addr0, a);
      chk("no_valid", 32'(fv0), 32'd0);
      if (i == l - 1) begin
        imem_ack   = 1'b1;
        imem_rdata = dat;
      end
      tick();
    end
    imem_ack = 1'b0;
    chk("dlv_valid", 32'(fv0), 32'd1);
    chk("dlv_pc", fpc0, a);
    chk("dlv_instr", fin0, dat);
    chk("dlv_req", 32'(req0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_req", 32'(req0), 32'd0);
    chk("rst_addr", addr0, 32'h0);
    chk("rst_addr1", addr1, 32'hFFFF_FFFC);
    chk("rst_valid", 32'(fv0), 32'd0);
    chk("rst_pc", fpc0, 32'h0);
    chk("rst_instr", fin0, 32'h0);

    // Sequential fetch 0,4,8 then stall, then C
    rst = 1'b1; en = 1'b1;
    tick();
    mpc = 32'h0;
    for (int k = 0; k < 3; k++) begin
      chk("seq_addr1", addr1, mpc - 32'd4);
      deliver(1, mpc, 32'hA000_0000 + mpc);
      mpc = mpc + 32'd4;
      if (k < 2) begin
        tick();
        chk("seq_drop", 32'(fv0), 32'd0);
      end
    end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(fv0), 32'd1);
      chk("stall_pc", fpc0, 32'h8);
      chk("stall_instr", fin0, 32'hA000_0008);
      chk("stall_req", 32'(req0), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("rel_valid", 32'(fv0), 32'd0);
    deliver(1, 32'hC, 32'hA000_000C);

    // Redirect from HOLD with unaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h5;
    tick();
    redirect_valid = 1'b0;
    chk("hold_redir_valid", 32'(fv0), 32'd0);
    chk("hold_redir_addr", addr0, 32'h4);
    chk("hold_redir_addr1", addr1, 32'h4);

    // Redirect while fetching 4, ack arrives later
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("flush_req", 32'(req0), 32'd1);
      chk("flush_addr", addr0, 32'h4);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    chk("flush_drop", 32'(fv0), 32'd0);
    deliver(1, 32'h100, 32'hA000_0100);

    // Redirect coincident with ack
    tick();
    chk("coin_pre_addr", addr0, 32'h104);
    imem_ack = 1'b1; imem_rdata = 32'hBAD1_BAD1;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    imem_ack = 1'b0; redirect_valid = 1'b0;
    chk("coin_drop", 32'(fv0), 32'd0);
    deliver(2, 32'h200, 32'hA000_0200);

    // Reset in the middle of a flush, stale ack afterwards
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("pre_rst_addr", addr0, 32'h204);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", 32'(req0), 32'd0);
    chk("arst_addr", addr0, 32'h0);
    chk("arst_addr1", addr1, 32'hFFFF_FFFC);
    chk("arst_valid", 32'(fv0), 32'd0);
    chk("arst_pc", fpc0, 32'h0);
    chk("arst_instr", fin0, 32'h0);
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hBAD2_BAD2;
    tick();
    tick();
    chk("stale_valid", 32'(fv0), 32'd0);
    chk("stale_req", 32'(req0), 32'd0);
    imem_ack = 1'b0; en = 1'b1;
    tick();
    chk("post_rst_addr1", addr1, 32'hFFFF_FFFC);
    deliver(1, 32'h0, 32'hA000_0000);
    mpc = 32'h4;
    tick();

    // Randomized traffic against the transaction model
    for (int it = 0; it < 40; it++) begin
      lat  = int'($urandom_range(1, 4));
      kind = int'($urandom_range(0, 4));
      d    = $urandom;
      if (kind <= 2) begin
        deliver(lat, mpc, d);
        old = mpc;
        mpc = mpc + 32'd4;
        n = int'($urandom_range(0, 3));
        stall = (n != 0);
        for (int i = 0; i < n; i++) begin
          tick();
          chk("r_stall_valid", 32'(fv0), 32'd1);
          chk("r_stall_pc", fpc0, old);
          chk("r_stall_instr", fin0, d);
        end
        stall = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          r1 = $urandom;
          redirect_valid = 1'b1; redirect_pc = r1;
          tick();
          redirect_valid = 1'b0;
          mpc = word_of(r1);
        end else begin
          tick();
        end
        chk("r_next_valid", 32'(fv0), 32'd0);
      end else if (kind == 3) begin
        old = mpc;
        r1 = $urandom;
        r2 = $urandom;
        redirect_valid = 1'b1; redirect_pc = r1;
        tick();
        redirect_pc = r2;
        tick();
        redirect_valid = 1'b0;
        chk("r_flush_addr", addr0, old);
        chk("r_flush_req", 32'(req0), 32'd1);
        imem_ack = 1'b1; imem_rdata = d;
        tick();
        imem_ack = 1'b0;
        chk("r_flush_drop", 32'(fv0), 32'd0);
        mpc = word_of(r2);
      end else begin
        for (int i = 1; i < lat; i++) begin
          chk("r_coin_addr", addr0, mpc);
          tick();
        end
        r1 = $urandom;
        imem_ack = 1'b1; imem_rdata = d;
        redirect_valid = 1'b1; redirect_pc = r1;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        chk("r_coin_drop", 32'(fv0), 32'd0);
        mpc = word_of(r1);
      end
      chk("r_iter_req", 32'(req0), 32'd1);
      chk("r_iter_addr", addr0, mpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
